// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says game controller.
// Covers state encoding, display codes and the LFSR-to-symbol mapping.
package simon_pkg;

  localparam int unsigned SYM_W       = 3;
  localparam int unsigned NUM_SYMBOLS = 6;
  localparam int unsigned DISP_W      = 8;
  localparam int unsigned LVL_W       = 5;
  localparam int unsigned LFSR_W      = 16;
  localparam int unsigned STATE_W     = 3;

  localparam logic [DISP_W-1:0] DISP_BLANK = 8'hFF;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t APPEND = 3'd1;
  localparam state_t GAP    = 3'd2;
  localparam state_t SHOW   = 3'd3;
  localparam state_t INPUT  = 3'd4;
  localparam state_t WIN    = 3'd5;
  localparam state_t LOSE   = 3'd6;

  // Registered output bundle presented to the display and LEDs
  typedef struct packed {
    logic [DISP_W-1:0] disp;
    logic              busy;
    logic              win;
    logic              lose;
  } status_t;

  // Fold the two out-of-range raw values (6, 7) back onto symbols 0 and 1
  function automatic logic [SYM_W-1:0] lfsr_to_sym(input logic [SYM_W-1:0] raw);
    logic [SYM_W-1:0] sym;
    sym = raw;
    if (raw >= SYM_W'(NUM_SYMBOLS)) begin
      sym = raw - SYM_W'(NUM_SYMBOLS);
    end
    return sym;
  endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Player/display-side signal bundle of the Simon sequencer.
// The controller takes the slave side; the surrounding datapath drives the master side.
interface simon_sequencer_if;
  import simon_pkg::*;

  logic              start;
  logic              key_valid;
  logic [SYM_W-1:0]  key_code;
  logic [DISP_W-1:0] disp_code;
  logic [LVL_W-1:0]  level;
  logic              busy;
  logic              win;
  logic              lose;

  modport master (
    output start, key_valid, key_code,
    input  disp_code, level, busy, win, lose
  );

  modport slave (
    input  start, key_valid, key_code,
    output disp_code, level, busy, win, lose
  );

endinterface

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) feeding new game symbols.
// Reloads SEED on reset; SEED must be nonzero or the register locks up at zero.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              feedback;

  always_comb begin
    feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d   = {lfsr_q[LFSR_W-2:0], feedback};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game controller: grows a random symbol sequence, plays it back on the
// display, then checks player key presses. MAX_LEN up to 31 fits the 5-bit level output.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned       MAX_LEN     = 16,
  parameter int unsigned       SHOW_CYCLES = 25000000,
  parameter int unsigned       GAP_CYCLES  = 12500000,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  simon_sequencer_if.slave bus_if
);

  localparam int unsigned TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned IDX_W   = $clog2(MAX_LEN);

  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(MAX_LEN);
  localparam status_t          OUT_RST   = '{disp: DISP_BLANK, busy: 1'b0, win: 1'b0, lose: 1'b0};

  state_t            state_q;
  state_t            state_d;
  logic [TMR_W-1:0]  timer_q;
  logic [TMR_W-1:0]  timer_d;
  logic [LVL_W-1:0]  index_q;
  logic [LVL_W-1:0]  index_d;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  status_t           out_q;
  status_t           out_d;

  logic [SYM_W-1:0]  seq_q [MAX_LEN];
  logic [SYM_W-1:0]  cur_sym;
  logic [SYM_W-1:0]  new_sym;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;

  simon_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .lfsr_o (lfsr)
  );

  // Only the low symbol bits drive the game; the rest just keep the LFSR long-period
  assign new_sym     = lfsr_to_sym(lfsr[SYM_W-1:0]);
  assign lfsr_unused = ^lfsr[LFSR_W-1:SYM_W];

  // index only reaches MAX_LEN in GAP, where the read value is not used
  assign cur_sym = seq_q[index_q[IDX_W-1:0]];

  // Sequence store: written once per round at the current level
  always_ff @(posedge clk) begin
    if (state_q == APPEND) begin
      seq_q[level_q[IDX_W-1:0]] <= new_sym;
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      index_q <= '0;
      level_q <= '0;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      index_q <= index_d;
      level_q <= level_d;
      out_q   <= out_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    index_d = index_q;
    level_d = level_q;

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (bus_if.start) begin
          state_d = APPEND;
          level_d = '0;
        end
      end

      APPEND: begin
        level_d = level_q + LVL_W'(1);
        index_d = '0;
        timer_d = '0;
        state_d = GAP;
      end

      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (index_q < level_q) begin
            state_d = SHOW;
          end else begin
            state_d = INPUT;
            index_d = '0;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      SHOW: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          index_d = index_q + LVL_W'(1);
          state_d = GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      // key_valid takes priority; start is never looked at here
      INPUT: begin
        if (bus_if.key_valid) begin
          if (bus_if.key_code == cur_sym) begin
            if (index_q == level_q - LVL_W'(1)) begin
              state_d = (level_q == LVL_MAX) ? WIN : APPEND;
            end else begin
              index_d = index_q + LVL_W'(1);
            end
          end else begin
            state_d = LOSE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the current state, registered one cycle later
  always_comb begin
    out_d = '{disp: DISP_BLANK, busy: 1'b1, win: 1'b0, lose: 1'b0};

    case (state_q)
      IDLE: begin
        out_d.busy = 1'b0;
      end
      SHOW: begin
        out_d.disp = DISP_W'(cur_sym);
      end
      WIN: begin
        out_d.busy = 1'b0;
        out_d.win  = 1'b1;
      end
      LOSE: begin
        out_d.busy = 1'b0;
        out_d.lose = 1'b1;
        out_d.disp = DISP_W'(cur_sym);
      end
      default: begin
      end
    endcase
  end

  assign bus_if.disp_code = out_q.disp;
  assign bus_if.level     = level_q;
  assign bus_if.busy      = out_q.busy;
  assign bus_if.win       = out_q.win;
  assign bus_if.lose      = out_q.lose;

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer with short timing (SHOW=4, GAP=2, MAX_LEN=3).
// Expected display symbols are queued at each round start and consumed by a display monitor.
module tb_simon_sequencer;

  localparam int unsigned SHOW  = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned MAXL  = 3;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [7:0]  BLANK = 8'hFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  exp_q[$];
  logic [2:0]  seq[$];

  int         lit_run   = 0;
  logic       lit_lose  = 1'b0;
  logic [7:0] prev_disp = 8'hFF;

  always #5 clk = ~clk;

  simon_sequencer_if bus_if ();

  simon_sequencer #(
    .MAX_LEN     (MAXL),
    .SHOW_CYCLES (SHOW),
    .GAP_CYCLES  (GAP),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  // Reference LFSR kept in lockstep with the DUT's free-running generator
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] sym_of(input logic [15:0] v);
    logic [2:0] r;
    r = v[2:0];
    if (r > 3'd5) r = r - 3'd6;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] code, input logic with_start);
    bus_if.key_valid = 1'b1;
    bus_if.key_code  = code;
    bus_if.start     = with_start;
    tick();
    bus_if.key_valid = 1'b0;
    bus_if.start     = 1'b0;
  endtask

  task automatic enter_round();
    foreach (seq[i]) press(seq[i], 1'b0);
  endtask

  // Called on the first sample with the DUT in APPEND; returns on the first INPUT sample.
  // Symbol j is lit on samples 4+6j .. 7+6j after the edge that entered APPEND.
  task automatic play_round(input int lvl, input bit poke, input int forced);
    logic [2:0] s;
    logic [7:0] expd;
    int         p;
    s = (forced >= 0) ? 3'(forced) : sym_of(m_lfsr);
    seq.push_back(s);
    check("append_level", 32'(bus_if.level), 32'(lvl - 1));
    foreach (seq[j]) exp_q.push_back({5'b0, seq[j]});
    tick();
    check("round_level", 32'(bus_if.level), 32'(lvl));
    check("round_busy", 32'(bus_if.busy), 32'd1);
    check("round_win", 32'(bus_if.win), 32'd0);
    check("round_lose", 32'(bus_if.lose), 32'd0);
    for (int k = 2; k <= 6 * lvl + 1; k++) begin
      if (poke && k == 5) begin
        bus_if.key_valid = 1'b1;
        bus_if.key_code  = 3'd7;
        bus_if.start     = 1'b1;
      end else begin
        bus_if.key_valid = 1'b0;
        bus_if.start     = 1'b0;
      end
      tick();
      p = k - 4;
      if (k >= 4 && (p % 6) < 4) expd = {5'b0, seq[p / 6]};
      else                       expd = BLANK;
      check("disp_trace", 32'(bus_if.disp_code), 32'(expd));
    end
    check("playback_done", 32'(exp_q.size()), 32'd0);
    check("playback_level", 32'(bus_if.level), 32'(lvl));
    check("playback_lose", 32'(bus_if.lose), 32'd0);
    tick_n(2);
  endtask

  // Display monitor: every newly lit symbol must match the next queued expectation
  always @(negedge clk) begin
    if (reset) begin
      lit_run   = 0;
      prev_disp = BLANK;
    end else begin
      if (bus_if.disp_code != BLANK && prev_disp == BLANK) begin
        if (exp_q.size() == 0) check("unexpected_symbol", 32'(bus_if.disp_code), 32'(BLANK));
        else                   check("symbol", 32'(bus_if.disp_code), 32'(exp_q.pop_front()));
        lit_run  = 1;
        lit_lose = bus_if.lose;
      end else if (bus_if.disp_code != BLANK) begin
        lit_run++;
      end else if (prev_disp != BLANK && !lit_lose) begin
        check("show_len", 32'(lit_run), 32'(SHOW));
      end
      prev_disp = bus_if.disp_code;
    end
  end

  initial begin
    bus_if.start     = 1'b0;
    bus_if.key_valid = 1'b0;
    bus_if.key_code  = 3'd0;

    // Power-up reset state
    tick_n(3);
    check("rst_disp", 32'(bus_if.disp_code), 32'(BLANK));
    check("rst_level", 32'(bus_if.level), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_win", 32'(bus_if.win), 32'd0);
    check("rst_lose", 32'(bus_if.lose), 32'd0);

    // Reset held three cycles in the middle of SHOW abandons the game
    reset = 1'b0;
    tick_n(2);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    seq.delete();
    seq.push_back(sym_of(m_lfsr));
    exp_q.push_back({5'b0, seq[0]});
    tick_n(5);
    check("mid_show_disp", 32'(bus_if.disp_code), 32'({5'b0, seq[0]}));
    reset = 1'b1;
    tick();
    check("midrst_disp", 32'(bus_if.disp_code), 32'(BLANK));
    check("midrst_level", 32'(bus_if.level), 32'd0);
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    tick_n(2);

    // Start on the first free-running edge: LFSR ACE1 -> 59C3, symbol 3
    reset        = 1'b0;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    seq.delete();
    play_round(1, 1'b0, 3);

    // Correct keys through level 3 reach WIN
    press(seq[0], 1'b0);
    play_round(2, 1'b0, -1);
    enter_round();
    play_round(3, 1'b0, -1);
    enter_round();
    tick();
    check("win_flag", 32'(bus_if.win), 32'd1);
    check("win_busy", 32'(bus_if.busy), 32'd0);
    check("win_lose", 32'(bus_if.lose), 32'd0);
    check("win_disp", 32'(bus_if.disp_code), 32'(BLANK));
    check("win_level", 32'(bus_if.level), 32'd3);
    press(seq[0], 1'b0);
    press(3'd7, 1'b0);
    tick();
    check("win_hold", 32'(bus_if.win), 32'd1);
    check("win_hold_level", 32'(bus_if.level), 32'd3);

    // New game from WIN, then lose at level 2 on the second key
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    seq.delete();
    play_round(1, 1'b0, -1);
    enter_round();
    play_round(2, 1'b0, -1);
    exp_q.push_back({5'b0, seq[1]});
    press(seq[0], 1'b0);
    press(3'd7, 1'b0);
    tick();
    check("lose_flag", 32'(bus_if.lose), 32'd1);
    check("lose_busy", 32'(bus_if.busy), 32'd0);
    check("lose_win", 32'(bus_if.win), 32'd0);
    check("lose_disp", 32'(bus_if.disp_code), 32'({5'b0, seq[1]}));
    check("lose_level", 32'(bus_if.level), 32'd2);

    // Key and start during SHOW, start during INPUT, key+start together in INPUT
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    seq.delete();
    play_round(1, 1'b1, -1);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("input_start_level", 32'(bus_if.level), 32'd1);
    tick_n(3);
    check("input_start_level2", 32'(bus_if.level), 32'd1);
    check("input_start_busy", 32'(bus_if.busy), 32'd1);
    check("input_start_disp", 32'(bus_if.disp_code), 32'(BLANK));
    press(seq[0], 1'b1);
    play_round(2, 1'b0, -1);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
